am2911_ctrl: RTL

AM2911_CTRL -- requirements
Module: am2911_ctrl

---
 rtl/am2911_ctrl_pkg.sv | 34 +++
 rtl/am2911_ctrl_dec.sv | 79 +++++++
 rtl/am2911_ctrl.sv | 103 ++++++++++
 3 files changed

// File: rtl/am2911_ctrl_pkg.sv
// Shared definitions for the Am2911 sequencer controller.
// Holds the next-address opcodes, the Am2911 source-select codes and the
// stack depth of the Am2911 file.
package am2911_ctrl_pkg;

  typedef enum logic [3:0] {
    JZ   = 4'd0,
    CJS  = 4'd1,
    JMAP = 4'd2,
    CJP  = 4'd3,
    PUSH = 4'd4,
    JSRP = 4'd5,
    CJV  = 4'd6,
    JRP  = 4'd7,
    RFCT = 4'd8,
    RPCT = 4'd9,
    CRTN = 4'd10,
    CJPP = 4'd11,
    LDCT = 4'd12,
    LOOP = 4'd13,
    CONT = 4'd14,
    TWB  = 4'd15
  } opcode_e;

  typedef enum logic [1:0] {
    SEL_UPC = 2'b00,
    SEL_AR  = 2'b01,
    SEL_STK = 2'b10,
    SEL_D   = 2'b11
  } sel_e;

  localparam int unsigned STACK_DEPTH = 4;

endpackage

// File: rtl/am2911_ctrl_dec.sv
// Combinational next-address decoder.
// Inputs : i (opcode), p (effective pass = test | ccen_), cnt_zero.
// Outputs: s, fe_, pup, zero_, pl_e_, map_e_, vect_e_ to the Am2911 and
//          D-source buffers; cnt_ld, cnt_dec, push, pop, clr strobes for the
//          counter and depth tracking held in the top.
module am2911_ctrl_dec
  import am2911_ctrl_pkg::*;
(
  input  logic [3:0] i,
  input  logic       p,
  input  logic       cnt_zero,
  output logic [1:0] s,
  output logic       fe_,
  output logic       pup,
  output logic       zero_,
  output logic       pl_e_,
  output logic       map_e_,
  output logic       vect_e_,
  output logic       cnt_ld,
  output logic       cnt_dec,
  output logic       push,
  output logic       pop,
  output logic       clr
);

  // fe_/pup follow directly from the push/pop strobes.
  logic push_c, pop_c, stk_x;

  always_comb begin
    s       = SEL_UPC;
    zero_   = 1'b1;
    pl_e_   = 1'b0;
    map_e_  = 1'b1;
    vect_e_ = 1'b1;
    cnt_ld  = 1'b0;
    cnt_dec = 1'b0;
    push_c  = 1'b0;
    pop_c   = 1'b0;
    clr     = 1'b0;
    stk_x   = 1'b0;
    case (i)
      JZ:   begin zero_ = 1'b0; clr = 1'b1; end
      CJS:  if (p) begin s = SEL_D; push_c = 1'b1; end
      JMAP: begin s = SEL_D; map_e_ = 1'b0; pl_e_ = 1'b1; end
      CJP:  if (p) s = SEL_D;
      PUSH: begin push_c = 1'b1; cnt_ld = p; end
      JSRP: begin push_c = 1'b1; s = p ? SEL_D : SEL_AR; end
      CJV:  begin if (p) s = SEL_D; vect_e_ = 1'b0; pl_e_ = 1'b1; end
      JRP:  s = p ? SEL_D : SEL_AR;
      RFCT: if (!cnt_zero) begin s = SEL_STK; cnt_dec = 1'b1; end
            else pop_c = 1'b1;
      RPCT: if (!cnt_zero) begin s = SEL_D; cnt_dec = 1'b1; end
      CRTN: if (p) begin s = SEL_STK; pop_c = 1'b1; end
      CJPP: if (p) begin s = SEL_D; pop_c = 1'b1; end
      LDCT: cnt_ld = 1'b1;
      LOOP: if (p) pop_c = 1'b1;
            else s = SEL_STK;
      CONT: s = SEL_UPC;
      TWB:  if (p) pop_c = 1'b1;
            else if (cnt_zero) begin s = SEL_D; pop_c = 1'b1; end
            else begin s = SEL_STK; cnt_dec = 1'b1; end
      default: begin
        // Unknown opcode: controls go X, state strobes stay inactive.
        s       = 'x;
        zero_   = 1'bx;
        pl_e_   = 1'bx;
        map_e_  = 1'bx;
        vect_e_ = 1'bx;
        stk_x   = 1'b1;
      end
    endcase
  end

  assign push = push_c;
  assign pop  = pop_c;
  assign fe_  = stk_x ? 1'bx : ~(push_c | pop_c);
  assign pup  = stk_x ? 1'bx : push_c;

endmodule

// File: rtl/am2911_ctrl.sv
// Am2911 microprogram sequencer controller.
// Decodes the 4-bit next-address instruction into Am2911 controls and keeps
// a loop counter plus a shadow of the Am2911 stack occupancy.
// Ports: cp clock, rst_ async active-low reset, i opcode, test/ccen_
//        condition, din counter load; s/fe_/pup/zero_ to the Am2911;
//        pl_e_/map_e_/vect_e_ D-source enables; cnt/cnt_zero counter;
//        depth/full/empty/ovf/unf stack status.
module am2911_ctrl
  import am2911_ctrl_pkg::*;
#(
  parameter int unsigned CWIDTH = 8
) (
  input  logic              cp,
  input  logic              rst_,
  input  logic [3:0]        i,
  input  logic              test,
  input  logic              ccen_,
  input  logic [CWIDTH-1:0] din,
  output logic [1:0]        s,
  output logic              fe_,
  output logic              pup,
  output logic              zero_,
  output logic              pl_e_,
  output logic              map_e_,
  output logic              vect_e_,
  output logic              cnt_zero,
  output logic [CWIDTH-1:0] cnt,
  output logic [2:0]        depth,
  output logic              full,
  output logic              empty,
  output logic              ovf,
  output logic              unf
);

  logic [CWIDTH-1:0] cnt_q, cnt_d;
  logic [2:0]        depth_q, depth_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              cnt_ld, cnt_dec, push, pop, clr;

  am2911_ctrl_dec u_dec (
    .i        (i),
    .p        (test | ccen_),
    .cnt_zero (cnt_zero),
    .s        (s),
    .fe_      (fe_),
    .pup      (pup),
    .zero_    (zero_),
    .pl_e_    (pl_e_),
    .map_e_   (map_e_),
    .vect_e_  (vect_e_),
    .cnt_ld   (cnt_ld),
    .cnt_dec  (cnt_dec),
    .push     (push),
    .pop      (pop),
    .clr      (clr)
  );

  always_comb begin
    cnt_d   = cnt_q;
    depth_d = depth_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    // Load wins over decrement should both ever be asserted.
    if (cnt_ld)       cnt_d = din;
    else if (cnt_dec) cnt_d = cnt_q - 1'b1;
    // JZ resets the stack and both sticky flags ahead of any push/pop.
    if (clr) begin
      depth_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (push) begin
      if (depth_q == 3'(STACK_DEPTH)) ovf_d = 1'b1;
      else                            depth_d = depth_q + 1'b1;
    end else if (pop) begin
      if (depth_q == '0) unf_d = 1'b1;
      else               depth_d = depth_q - 1'b1;
    end
  end

  always_ff @(posedge cp or negedge rst_) begin
    if (!rst_) begin
      cnt_q   <= '0;
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign cnt      = cnt_q;
  assign cnt_zero = (cnt_q == '0);
  assign depth    = depth_q;
  assign full     = (depth_q == 3'(STACK_DEPTH));
  assign empty    = (depth_q == '0);
  assign ovf      = ovf_q;
  assign unf      = unf_q;

endmodule
